// File: rtl/mem_arbiter.sv
// Two-port arbiter for the single-port CPU memory: instruction fetch (port 0) and data (port 1).
// Grants one request at a time, sequences the memory's registered read/write timing, and acks.
module mem_arbiter #(
   parameter int DEPTH     = 32,
   parameter int FIXED_PRI = 0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic [11:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_ack,
   output logic        p0_err,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic [11:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_ack,
   output logic        p1_err,
   output logic [31:0] p1_rdata,
   output logic [11:0] m_addr,
   inout  wire  [31:0] m_data,
   output logic        m_rw_
);

   typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_t;

   localparam logic [12:0] DEPTH_LIM = 13'(DEPTH);

   state_t      state_reg;
   logic        owner_reg;
   logic        last_grant_reg;
   logic        oor_reg;
   logic        we_reg;
   logic [31:0] wdata_reg;

   logic        elig0;
   logic        elig1;
   logic        grant_next;
   logic        sel_we;
   logic        sel_oor;
   logic [11:0] sel_addr;
   logic [31:0] sel_wdata;

   // A port whose ack is high this cycle is not eligible, forcing a one-cycle gap.
   always_comb begin
      elig0 = p0_req & ~p0_ack;
      elig1 = p1_req & ~p1_ack;
      if (elig0 && elig1)
         grant_next = (FIXED_PRI != 0) ? 1'b1 : ~last_grant_reg;
      else
         grant_next = elig1;
      sel_addr  = grant_next ? p1_addr  : p0_addr;
      sel_we    = grant_next ? p1_we    : p0_we;
      sel_wdata = grant_next ? p1_wdata : p0_wdata;
      sel_oor   = ({1'b0, sel_addr} >= DEPTH_LIM);
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_grant_reg <= 1'b1;
         oor_reg        <= 1'b0;
         we_reg         <= 1'b0;
         wdata_reg      <= '0;
         m_addr         <= '0;
         m_rw_          <= 1'b1;
         p0_ack         <= 1'b0;
         p0_err         <= 1'b0;
         p0_rdata       <= '0;
         p1_ack         <= 1'b0;
         p1_err         <= 1'b0;
         p1_rdata       <= '0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         case (state_reg)
            IDLE: begin
               m_rw_ <= 1'b1;
               if (elig0 || elig1) begin
                  owner_reg      <= grant_next;
                  last_grant_reg <= grant_next;
                  m_addr         <= sel_addr;
                  we_reg         <= sel_we;
                  wdata_reg      <= sel_wdata;
                  oor_reg        <= sel_oor;
                  // Out-of-range writes never reach the memory.
                  m_rw_          <= ~(sel_we & ~sel_oor);
                  state_reg      <= ACCESS;
               end
            end
            ACCESS: begin
               m_rw_ <= 1'b1;
               if (oor_reg || we_reg) begin
                  state_reg <= IDLE;
                  if (owner_reg) begin
                     p1_ack <= 1'b1;
                     p1_err <= oor_reg;
                     if (oor_reg) p1_rdata <= '0;
                  end else begin
                     p0_ack <= 1'b1;
                     p0_err <= oor_reg;
                     if (oor_reg) p0_rdata <= '0;
                  end
               end else begin
                  state_reg <= CAPTURE;
               end
            end
            CAPTURE: begin
               state_reg <= IDLE;
               if (owner_reg) begin
                  p1_ack   <= 1'b1;
                  p1_err   <= 1'b0;
                  p1_rdata <= m_data;
               end else begin
                  p0_ack   <= 1'b1;
                  p0_err   <= 1'b0;
                  p0_rdata <= m_data;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign m_data = m_rw_ ? 32'bz : wdata_reg;

endmodule
